// File: rtl/subs_engine_pkg.sv
// Shared cipher definitions: S-box tables, FSM state encoding, default width.
package subs_engine_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;

  // Tables packed with entry i at bits [4*i +: 4], so entry 0 is the lowest nibble.
  // Forward: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
  localparam logic [63:0] SBOX_FWD = 64'h2174_8FE3_DA09_B65C;
  // Inverse: 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A
  localparam logic [63:0] SBOX_INV = 64'hA970_364B_D21C_8FE5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sbox_dual.sv
// Combinational 4-bit S-box with forward/inverse select.
module sbox_dual
  import subs_engine_pkg::*;
(
  input  logic [3:0] din,
  input  logic       inv,
  output logic [3:0] dout
);

  logic [5:0] idx;

  // Table lookup: nibble i of the selected packed table.
  always_comb begin
    idx  = {din, 2'b00};
    dout = inv ? SBOX_INV[idx +: 4] : SBOX_FWD[idx +: 4];
  end

endmodule

// File: rtl/subs_engine.sv
// Iterative nibble-substitution engine: LANES S-boxes per cycle, BEATS cycles per block,
// valid/ready handshake on both sides, one block in flight.
module subs_engine
  import subs_engine_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned BEATS   = NIBBLES / LANES;
  localparam int unsigned CW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned GW      = 4 * LANES;
  localparam int unsigned OW      = $clog2(WIDTH);

  if ((WIDTH % 4 != 0) || (LANES == 0) || (NIBBLES % LANES != 0)) begin : g_bad_params
    $error("subs_engine: WIDTH must be a multiple of 4 and WIDTH/4 a multiple of LANES");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    beat_q, beat_d;
  logic             inv_q, inv_d;

  logic [OW-1:0]    grp_off;
  logic [GW-1:0]    grp_cur;
  logic [GW-1:0]    grp_sub;
  logic             last_beat;

  // Nibble group currently being processed, selected by the beat counter.
  always_comb begin
    grp_off   = OW'(beat_q) * OW'(GW);
    grp_cur   = data_q[grp_off +: GW];
    last_beat = (beat_q == CW'(BEATS - 1));
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_dual u_sbox (
      .din  (grp_cur[4*i +: 4]),
      .inv  (inv_q),
      .dout (grp_sub[4*i +: 4])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last_beat) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs, decoded from state only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == BUSY);
    out_data  = data_q;
  end

  // Datapath next state: load on accept, substitute one group per BUSY cycle.
  always_comb begin
    data_d = data_q;
    beat_d = beat_q;
    inv_d  = inv_q;
    if (state_q == IDLE && in_valid) begin
      data_d = in_data;
      inv_d  = in_inv;
      beat_d = '0;
    end else if (state_q == BUSY) begin
      data_d[grp_off +: GW] = grp_sub;
      beat_d = beat_q + CW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      beat_q <= '0;
      inv_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      beat_q <= beat_d;
      inv_q  <= inv_d;
    end
  end

endmodule

// File: doc/subs_engine.md
SUBS_ENGINE -- requirements
Module: subs_engine

Interface
REQ-001 Parameter WIDTH, default 64: datapath width in bits, a multiple of 4.
REQ-002 Parameter LANES, default 4: S-boxes applied per cycle; (WIDTH/4) SHALL be a multiple of LANES, checked at elaboration.
REQ-003 Derived constant BEATS = WIDTH/(4*LANES), the processing cycles per block.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  a block is offered.
REQ-007 in_ready  out  1  the block can be accepted this cycle.
REQ-008 in_data  in  WIDTH  block to substitute.
REQ-009 in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled with the block.
REQ-010 out_valid  out  1  the result is held.
REQ-011 out_ready  in  1  the consumer takes the result.
REQ-012 out_data  out  WIDTH  substituted block.
REQ-013 busy  out  1  high in BUSY state.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 In IDLE, in_valid=1 SHALL cause the following on the same edge:
- in_data is loaded into the working register;
- in_inv is latched;
- the beat counter is cleared;
- the FSM moves to BUSY.
REQ-017 In BUSY, each cycle SHALL replace nibble group k (nibbles k*LANES .. k*LANES+LANES-1, nibble 0 = bits 3:0) with its S-box image, where k is the beat counter, then increment k.
REQ-018 After the beat with k = BEATS-1, the FSM SHALL enter DONE; out_valid SHALL therefore rise exactly BEATS cycles after the accepting edge (4 cycles at the defaults).
REQ-019 When BEATS = 1, the FSM SHALL go from BUSY to DONE after a single cycle.
REQ-020 The S-box SHALL be the forward table C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 (index 0..F).
REQ-021 The inverse S-box SHALL be the table 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
REQ-022 The latched mode SHALL apply to all beats of the block; in_inv changes during BUSY SHALL have no effect.
REQ-023 In DONE, out_data SHALL be held stable while out_ready=0, for any number of cycles.
REQ-024 In DONE with out_ready=1, the FSM SHALL return to IDLE; a new block SHALL NOT be accepted on that same edge.
REQ-025 out_data SHALL equal the working register in every state.
REQ-026 in_valid in BUSY or DONE SHALL be ignored; no buffering of a second block.

Reset
REQ-027 rst_n=0 SHALL force the following immediately, regardless of clk:
- state = IDLE;
- in_ready = 1, out_valid = 0, busy = 0;
- working register = 0, beat counter = 0, latched mode = 0.
REQ-028 Reset asserted mid-BUSY or mid-DONE SHALL discard the block; no partial result SHALL be presented after release.
REQ-029 Deassertion of rst_n SHALL take effect synchronously to clk.

Structure
REQ-030 The forward and inverse S-box tables, the FSM state enum and the default WIDTH SHALL reside in the shared cipher package.
REQ-031 A sub-module sbox_dual (4-bit in, 4-bit out, inv select, combinational) SHALL be instantiated LANES times by a generate loop.
REQ-032 Lane selection SHALL use an indexed part-select driven by the beat counter; no per-width hand instantiation.

Verification
REQ-033 WIDTH=64, LANES=4, forward mode, in_data=0 -> out_data=CCCCCCCCCCCCCCCC with out_valid rising 4 cycles after acceptance.
REQ-034 Forward, in_data=0123456789ABCDEF -> C56B90AD3EF84712; then inverse of C56B90AD3EF84712 -> 0123456789ABCDEF.
REQ-035 out_ready held 0 for 10 cycles in DONE -> out_data stable, in_ready=0 and in_valid ignored throughout; out_ready=1 -> IDLE on the next edge.
REQ-036 rst_n pulsed low during beat 2 -> outputs reset immediately; the next block 0 gives CCCC... with normal latency.
REQ-037 LANES=16 (BEATS=1) and LANES=1 (BEATS=16) -> latencies of 1 and 16 cycles, and REQ-034 vectors match.
REQ-038 in_inv toggled every cycle during BUSY -> result matches the mode sampled at acceptance.
